// File: rtl/cmt_din_fifo.sv
// ============================================================================
//  Module      : cmt_din_fifo
//  Description : CMT receive byte FIFO with an Avalon-MM register slave
//                (DATA / STATUS / CONTROL) and a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmt_din_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [7:0]  in_data,
   input  logic        in_strobe,
   output logic        irq
);

   localparam int                  c_DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_FULL_CNT    = c_DEPTH[DEPTH_LOG2:0];
   localparam logic [1:0]          c_ADDR_DATA   = 2'd0;
   localparam logic [1:0]          c_ADDR_STATUS = 2'd1;
   localparam logic [1:0]          c_ADDR_CTRL   = 2'd2;

   logic [7:0]            r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_ovf;
   logic                  r_irq_en;

   logic w_rd_cyc;
   logic w_wr_cyc;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_flush;
   logic w_drop;
   logic w_ovf_clr;
   logic w_unused;

   assign w_rd_cyc  = chipselect & ~read_n;
   assign w_wr_cyc  = chipselect & ~write_n;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_FULL_CNT);
   assign w_pop     = w_rd_cyc & (address == c_ADDR_DATA) & ~w_empty;
   assign w_flush   = w_wr_cyc & (address == c_ADDR_CTRL) & writedata[1];
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_push    = in_strobe & (~w_full | w_pop);
   assign w_drop    = in_strobe & w_full & ~w_pop & ~w_flush;
   assign w_ovf_clr = w_wr_cyc & (address == c_ADDR_STATUS) & writedata[10];
   assign w_unused  = &{1'b0, writedata[31:11], writedata[9:2]};

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (reset_n && w_push && !w_flush) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ovf    <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_wr_cyc && (address == c_ADDR_CTRL)) begin
            r_irq_en <= writedata[0];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         c_ADDR_DATA: begin
            if (!w_empty) begin
               readdata[8:0] = {1'b1, r_mem[r_rd_ptr]};
            end
         end
         c_ADDR_STATUS: begin
            readdata[DEPTH_LOG2:0] = r_count;
            readdata[8]            = w_empty;
            readdata[9]            = w_full;
            readdata[10]           = r_ovf;
         end
         c_ADDR_CTRL: begin
            readdata[0] = r_irq_en;
         end
         default: begin
            readdata = '0;
         end
      endcase
   end

   assign irq = r_irq_en & ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_cmt_din_fifo.sv
// ============================================================================
//  Module      : tb_cmt_din_fifo
//  Description : Self-checking bench for cmt_din_fifo (vectors, corner
//                sequences, random traffic against a queue model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmt_din_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 1 << DL2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd3;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  in_data = '0;
   logic        in_strobe = 1'b0;
   logic        irq;

   always #5 clk = ~clk;

   cmt_din_fifo #(.DEPTH_LOG2(DL2)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_data    (in_data),
      .in_strobe  (in_strobe),
      .irq        (irq)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a byte queue plus two flags.
   logic [7:0] mq[$];
   logic       m_ovf   = 1'b0;
   logic       m_irqen = 1'b0;

   logic [31:0] s_rd, m_rd;
   logic        s_irq, m_irq;

   typedef struct {
      logic        rstn;
      logic [1:0]  a;
      logic        cs, rd, wr;
      logic [31:0] wd;
      logic        stb;
      logic [7:0]  din;
      logic        chk;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic rstn, input logic [1:0] a,
                               input logic cs, input logic rd, input logic wr,
                               input logic [31:0] wd, input logic stb,
                               input logic [7:0] din, input logic chk,
                               input logic [31:0] exp_rd, input logic exp_irq);
      vec_t v;
      v.rstn = rstn; v.a = a; v.cs = cs; v.rd = rd; v.wr = wr; v.wd = wd;
      v.stb = stb; v.din = din; v.chk = chk; v.exp_rd = exp_rd;
      v.exp_irq = exp_irq;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_out(input logic [1:0] a);
      int n;
      n = mq.size();
      m_rd = '0;
      case (a)
         2'd0: if (n > 0) m_rd = 32'h100 | 32'(mq[0]);
         2'd1: m_rd = 32'(n) | ((n == 0) ? 32'h100 : 32'h0)
                    | ((n == DEPTH) ? 32'h200 : 32'h0)
                    | (m_ovf ? 32'h400 : 32'h0);
         2'd2: m_rd = {31'b0, m_irqen};
         default: m_rd = '0;
      endcase
      m_irq = m_irqen && (n > 0);
   endtask

   task automatic model_step(input logic rstn, input logic [1:0] a,
                             input logic cs, input logic rd, input logic wr,
                             input logic [31:0] wd, input logic stb,
                             input logic [7:0] din);
      logic pop, flush, set;
      if (!rstn) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_irqen = 1'b0;
      end else begin
         pop   = cs && rd && (a == 2'd0) && (mq.size() > 0);
         flush = cs && wr && (a == 2'd2) && wd[1];
         set   = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (stb) begin
               if (mq.size() < DEPTH) mq.push_back(din);
               else set = 1'b1;
            end
         end
         if (set) m_ovf = 1'b1;
         else if (cs && wr && (a == 2'd1) && wd[10]) m_ovf = 1'b0;
         if (cs && wr && (a == 2'd2)) m_irqen = wd[0];
      end
   endtask

   // Drive one bus cycle, sample at the falling edge, advance the model.
   task automatic cyc(input logic rstn, input logic [1:0] a, input logic cs,
                      input logic rd, input logic wr, input logic [31:0] wd,
                      input logic stb, input logic [7:0] din);
      reset_n = rstn; address = a; chipselect = cs; read_n = ~rd;
      write_n = ~wr; writedata = wd; in_strobe = stb; in_data = din;
      @(negedge clk);
      s_rd  = readdata;
      s_irq = irq;
      model_out(a);
      @(posedge clk);
      model_step(rstn, a, cs, rd, wr, wd, stb, din);
      #1;
      reset_n = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      writedata = '0; in_strobe = 1'b0; address = 2'd3;
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a,
                         input logic [31:0] exp);
      cyc(1'b1, a, 1'b1, 1'b1, 1'b0, '0, 1'b0, 8'h00);
      chk(nm, s_rd, exp);
      chk({nm, "_irq"}, {31'b0, s_irq}, {31'b0, m_irq});
   endtask

   task automatic push(input logic [7:0] b);
      cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, '0, 1'b1, b);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ne;
      @(posedge clk); #1;

      // Reset, basic push/pop with irq, flush with concurrent strobe.
      vt.push_back(mk(0, 3, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h000, 0));
      vt.push_back(mk(1, 1, 1, 1, 0, 0, 0, 8'h00, 1, 32'h100, 0));
      vt.push_back(mk(1, 2, 1, 1, 0, 0, 0, 8'h00, 1, 32'h000, 0));
      vt.push_back(mk(1, 3, 1, 1, 0, 0, 0, 8'h00, 1, 32'h000, 0));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 1, 8'h11, 1, 32'h000, 0));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 1, 8'h22, 1, 32'h000, 0));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 1, 8'h33, 1, 32'h000, 0));
      vt.push_back(mk(1, 2, 1, 0, 1, 32'h1, 0, 8'h00, 1, 32'h000, 0));
      vt.push_back(mk(1, 1, 1, 1, 0, 0, 0, 8'h00, 1, 32'h003, 1));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h111, 1));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h122, 1));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h133, 1));
      vt.push_back(mk(1, 1, 1, 1, 0, 0, 0, 8'h00, 1, 32'h100, 0));
      vt.push_back(mk(1, 2, 1, 1, 0, 0, 0, 8'h00, 1, 32'h001, 0));
      vt.push_back(mk(1, 2, 1, 0, 1, 32'h0, 0, 8'h00, 1, 32'h001, 0));
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(1, 3, 0, 0, 0, 0, 1, 8'(8'h40 + i), 1, 32'h000, 0));
      vt.push_back(mk(1, 2, 1, 0, 1, 32'h2, 1, 8'h55, 1, 32'h000, 0));
      vt.push_back(mk(1, 1, 1, 1, 0, 0, 0, 8'h00, 1, 32'h100, 0));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h000, 0));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 1, 8'h66, 1, 32'h000, 0));
      vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 32'h166, 0));
      vt.push_back(mk(1, 1, 1, 1, 0, 0, 0, 8'h00, 1, 32'h100, 0));

      foreach (vt[k]) begin
         cyc(vt[k].rstn, vt[k].a, vt[k].cs, vt[k].rd, vt[k].wr, vt[k].wd,
             vt[k].stb, vt[k].din);
         if (vt[k].chk) begin
            chk($sformatf("vec%0d_rd", k), s_rd, vt[k].exp_rd);
            chk($sformatf("vec%0d_irq", k), {31'b0, s_irq},
                {31'b0, vt[k].exp_irq});
         end
      end

      // Overflow: the 17th byte is dropped.
      for (int i = 0; i <= 16; i++) push(8'(i));
      rd_chk("ovf_status", 2'd1, 32'h610);
      for (int i = 0; i < 16; i++)
         rd_chk($sformatf("ovf_data%0d", i), 2'd0, 32'h100 + 32'(i));
      rd_chk("ovf_status_empty", 2'd1, 32'h500);
      cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 8'h00);
      rd_chk("ovf_cleared", 2'd1, 32'h100);

      // Push into a full FIFO during a pop.
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      cyc(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 8'hAA);
      chk("full_pushpop_rd", s_rd, 32'h120);
      rd_chk("full_pushpop_status", 2'd1, 32'h210);
      for (int i = 1; i < 16; i++)
         rd_chk($sformatf("full_data%0d", i), 2'd0, 32'h120 + 32'(i));
      rd_chk("full_last_aa", 2'd0, 32'h1AA);
      rd_chk("full_drained", 2'd1, 32'h100);

      // Interleaved stream with pointer wrap, then reset mid-stream.
      cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00);
      ne = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 2'd0, i >= 3, i >= 3, 1'b0, '0, 1'b1, 8'(8'h80 + i));
         chk($sformatf("wrap_rd%0d", i), s_rd,
             (i == 0) ? 32'h0 : 32'h180 + 32'(ne));
         chk($sformatf("wrap_irq%0d", i), {31'b0, s_irq}, (i == 0) ? 0 : 1);
         if (i >= 3) ne++;
      end
      rd_chk("wrap_next", 2'd0, 32'h180 + 32'(ne));
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h77);
      rd_chk("rst_status", 2'd1, 32'h100);
      rd_chk("rst_ctrl", 2'd2, 32'h000);
      rd_chk("rst_data", 2'd0, 32'h000);

      // Random traffic against the queue model.
      for (int n = 0; n < 4000; n++) begin
         logic [1:0]  a;
         logic        cs, rd, wr, stb, rstn;
         logic [31:0] wd;
         int          op;
         op   = $urandom_range(0, 99);
         a    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
         wd   = $urandom;
         if (a == 2'd2) wd[1] = ($urandom_range(0, 15) == 0);
         cs   = (op < 60);
         rd   = (op < 40);
         wr   = (op >= 40) && (op < 60);
         stb  = ($urandom_range(0, 99) < 55);
         rstn = ($urandom_range(0, 299) != 0);
         cyc(rstn, a, cs, rd, wr, wd, stb, 8'($urandom));
         chk($sformatf("rnd%0d_rd", n), s_rd, m_rd);
         chk($sformatf("rnd%0d_irq", n), {31'b0, s_irq}, {31'b0, m_irq});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
